// File: rtl/seg_pkg.sv
// Shared types and hex-to-segment decode for the seven-segment frame controller.
package seg_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NUM_REQ    = 2;
   localparam int unsigned SEG_W      = 8;
   localparam int unsigned DIGIT_W    = 2;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_BLANK = 8'h00;

   // Resolved write into the shadow frame: target digit and final segment pattern
   typedef struct packed {
      logic [DIGIT_W-1:0] digit;
      seg_t               seg;
   } seg_wr_t;

   // Segments a..g on bits 0..6, dp (bit 7) left clear
   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      seg_t s;
      case (nib)
         4'h0: s = 8'h3F;
         4'h1: s = 8'h06;
         4'h2: s = 8'h5B;
         4'h3: s = 8'h4F;
         4'h4: s = 8'h66;
         4'h5: s = 8'h6D;
         4'h6: s = 8'h7D;
         4'h7: s = 8'h07;
         4'h8: s = 8'h7F;
         4'h9: s = 8'h6F;
         4'hA: s = 8'h77;
         4'hB: s = 8'h7C;
         4'hC: s = 8'h39;
         4'hD: s = 8'h5E;
         4'hE: s = 8'h79;
         default: s = 8'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/segment_frame_ctrl_if.sv
// Per-digit write request bus from two requesters into the frame controller.
interface segment_frame_ctrl_if;
   import seg_pkg::*;

   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0]                 req_ready;
   logic [NUM_REQ-1:0][DIGIT_W-1:0]    req_digit;
   logic [NUM_REQ-1:0]                 req_raw;
   logic [NUM_REQ-1:0][SEG_W-1:0]      req_data;

   modport master (
      output req_valid, req_digit, req_raw, req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_digit, req_raw, req_data,
      output req_ready
   );
endinterface

// File: rtl/seg_rr_arb2.sv
// Two-way round-robin arbiter; ready is combinational, pointer moves to the loser after a grant.
module seg_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   output logic [1:0] ready
);

   logic rr;

   always_comb begin
      ready = valid;
      if (valid == 2'b11) begin
         ready = rr ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr <= 1'b0;
      end else if (|(valid & ready)) begin
         rr <= ~ready[1];
      end
   end

endmodule

// File: rtl/segment_frame_ctrl.sv
// Shadow/commit frame controller for a 4-digit seven-segment display.
// Optional blink masking is built when SEG_FRAME_BLINK_EN is defined.
module segment_frame_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 100_000_000,
   parameter int unsigned BLINK_HZ = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   segment_frame_ctrl_if.slave     req,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   input  logic                    frame_sync,
   output seg_t [NUM_DIGITS-1:0]   chars,
   output logic                    dirty
);

   seg_t [NUM_DIGITS-1:0] shadow;
   seg_t [NUM_DIGITS-1:0] frame;
   logic                  xfer;
   logic                  sel;
   seg_wr_t               wr;

   seg_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .valid (req.req_valid),
      .ready (req.req_ready)
   );

   // Pick the granted requester and resolve its payload to a segment pattern
   always_comb begin
      xfer     = |(req.req_valid & req.req_ready);
      sel      = req.req_ready[1];
      wr.digit = req.req_digit[sel];
      wr.seg   = hex_to_seg(req.req_data[sel][3:0]) | {req.req_data[sel][7], 7'b0};
      if (req.req_raw[sel]) begin
         wr.seg = req.req_data[sel];
      end
   end

   // Commit reads the pre-write shadow, so a coincident write stays dirty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         frame  <= '0;
         dirty  <= 1'b0;
      end else begin
         if (frame_sync && dirty) begin
            frame <= shadow;
            dirty <= 1'b0;
         end
         if (xfer) begin
            shadow[wr.digit] <= wr.seg;
            dirty            <= 1'b1;
         end
      end
   end

`ifdef SEG_FRAME_BLINK_EN
   localparam int unsigned HALF  = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CNT_W-1:0] cnt;
   logic             phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (cnt == CNT_W'(HALF - 1)) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chars <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            chars[i] <= (phase || !blink_en[i]) ? frame[i] : SEG_BLANK;
         end
      end
   end
`else
   logic unused_blink;
   assign unused_blink = ^{blink_en, 1'(CLK_HZ), 1'(BLINK_HZ)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chars <= '0;
      end else begin
         chars <= frame;
      end
   end
`endif

endmodule

// File: tb/tb_segment_frame_ctrl.sv
// Randomized and directed bench for segment_frame_ctrl against a cycle-level reference model.
module tb_segment_frame_ctrl;

   localparam int unsigned CLK_HZ   = 8;
   localparam int unsigned BLINK_HZ = 1;
   localparam int unsigned HALF     = CLK_HZ / (2 * BLINK_HZ);
`ifdef SEG_FRAME_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] blink_en;
   logic frame_sync;
   logic [3:0][7:0] chars;
   logic dirty;

   segment_frame_ctrl_if bus ();

   segment_frame_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (bus),
      .blink_en   (blink_en),
      .frame_sync (frame_sync),
      .chars      (chars),
      .dirty      (dirty)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   // Reference state
   logic [7:0] m_shadow [4];
   logic [7:0] m_frame  [4];
   logic [3:0][7:0] m_chars;
   logic m_dirty;
   logic m_rr;
   int unsigned m_edges;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_ready();
      if (bus.req_valid == 2'b11) return m_rr ? 2'b10 : 2'b01;
      return bus.req_valid;
   endfunction

   function automatic logic [7:0] encode(input logic raw, input logic [7:0] d);
      if (raw) return d;
      return hex_tab[d[3:0]] | {d[7], 7'b0};
   endfunction

   // Model: one evaluation per clock edge, working on whole-frame arrays
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 8'h00;
            m_frame[i]  = 8'h00;
         end
         m_chars = '0;
         m_dirty = 1'b0;
         m_rr    = 1'b0;
         m_edges = 0;
      end else begin
         logic [1:0] g;
         logic visible;
         int k;
         g = exp_ready();
         visible = !BLINK || (((m_edges / HALF) % 2) == 0);
         for (int i = 0; i < 4; i++)
            m_chars[i] = (visible || !blink_en[i]) ? m_frame[i] : 8'h00;
         m_edges++;
         if (frame_sync && m_dirty) begin
            for (int i = 0; i < 4; i++) m_frame[i] = m_shadow[i];
            m_dirty = 1'b0;
         end
         if (g != 2'b00) begin
            k = g[1] ? 1 : 0;
            m_shadow[bus.req_digit[k]] = encode(bus.req_raw[k], bus.req_data[k]);
            m_dirty = 1'b1;
            m_rr = (k == 0);
         end
      end
   end

   // Called at posedge+1; checks ready before the edge and registered outputs after it
   task automatic tick();
      #2;
      check("ready", 32'(bus.req_ready), 32'(exp_ready()));
      @(posedge clk);
      #1;
      check("chars", chars, m_chars);
      check("dirty", 32'(dirty), 32'(m_dirty));
   endtask

   task automatic set_req(input int k, input logic [1:0] digit, input logic raw, input logic [7:0] data);
      bus.req_digit[k] = digit;
      bus.req_raw[k]   = raw;
      bus.req_data[k]  = data;
   endtask

   logic [1:0] rr_pat [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   int zeros, shown;

   initial begin
      rst_n = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_digit = '0;
      bus.req_raw   = '0;
      bus.req_data  = '0;
      blink_en   = 4'b0000;
      frame_sync = 1'b0;

      // Reset with both requesters valid
      #12;
      check("rst_chars", chars, 32'h0);
      check("rst_dirty", 32'(dirty), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_ready", 32'(bus.req_ready), 32'h1);
      bus.req_valid = 2'b00;
      @(posedge clk);
      #1;

      // Hex 5 with dp to digit 2, junk in [6:4]
      bus.req_valid = 2'b01;
      set_req(0, 2'd2, 1'b0, 8'hF5);
      tick();
      bus.req_valid = 2'b00;
      check("wr_dirty", 32'(dirty), 32'h1);
      check("wr_chars_hold", chars, 32'h0);
      tick();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      tick();
      check("commit_d2", 32'(chars[2]), 32'hED);
      check("commit_dirty", 32'(dirty), 32'h0);

      // Solo req1 then both valid: grants alternate starting at req0
      bus.req_valid = 2'b10;
      set_req(1, 2'd0, 1'b1, 8'h49);
      tick();
      bus.req_valid = 2'b11;
      set_req(0, 2'd3, 1'b0, 8'h01);
      for (int i = 0; i < 4; i++) begin
         #2;
         check("rr_grant", 32'(bus.req_ready), 32'(rr_pat[i]));
         tick();
      end
      bus.req_valid = 2'b00;
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      tick();
      check("raw_d0", 32'(chars[0]), 32'h49);
      check("hex_d3", 32'(chars[3]), 32'h06);

      // Write coincident with frame_sync lands only at the next commit
      bus.req_valid = 2'b01;
      set_req(0, 2'd1, 1'b0, 8'h07);
      frame_sync = 1'b1;
      tick();
      bus.req_valid = 2'b00;
      frame_sync = 1'b0;
      tick();
      check("coincident_hold", 32'(chars[1]), 32'h00);
      check("coincident_dirty", 32'(dirty), 32'h1);
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      tick();
      check("coincident_next", 32'(chars[1]), 32'h07);

      // Blink on digit 0 holding 0x06
      bus.req_valid = 2'b01;
      set_req(0, 2'd0, 1'b1, 8'h06);
      tick();
      bus.req_valid = 2'b00;
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      blink_en = 4'b0001;
      tick();
      zeros = 0;
      shown = 0;
      for (int i = 0; i < 2 * int'(HALF); i++) begin
         tick();
         if (chars[0] == 8'h00) zeros++;
         if (chars[0] == 8'h06) shown++;
      end
      check("blink_off_cycles", 32'(zeros), BLINK ? 32'(HALF) : 32'h0);
      check("blink_on_cycles", 32'(shown), BLINK ? 32'(HALF) : 32'(2 * HALF));

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         bus.req_valid = 2'($urandom_range(0, 3));
         for (int k = 0; k < 2; k++)
            set_req(k, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
         blink_en   = 4'($urandom_range(0, 15));
         frame_sync = ($urandom_range(0, 3) == 0);
         tick();
      end
      bus.req_valid = 2'b00;
      frame_sync = 1'b0;

      // Reset mid-operation with an uncommitted write
      bus.req_valid = 2'b01;
      set_req(0, 2'd3, 1'b1, 8'hAA);
      tick();
      bus.req_valid = 2'b00;
      check("pre_rst_dirty", 32'(dirty), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_chars", chars, 32'h0);
      check("midrst_dirty", 32'(dirty), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      tick();
      check("post_rst_chars", chars, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
